// File: rtl/mm_ctrl_pkg.sv
// Shared opcodes, response bytes and FSM state type for the UART
// matrix-multiply command sequencer.
package mm_ctrl_pkg;

  localparam logic [7:0] CMD_MATRIX_MULT = 8'h4D;
  localparam logic [7:0] ACK             = 8'h06;
  localparam logic [7:0] NACK            = 8'h15;

  typedef enum logic [3:0] {
    IDLE,
    DIM,
    CHECK,
    SEND_ACK,
    SEND_NACK,
    LOAD_A,
    LOAD_H,
    START,
    COMPUTE,
    RD,
    RD_CAP,
    TX_BYTE,
    TX_WAIT
  } state_t;

  function automatic logic dim_ok(
    input logic [7:0] d,
    input int         max
  );
    return (d != 8'd0) && (int'(d) <= max);
  endfunction

endpackage

// File: rtl/uart_mm_ctrl_if.sv
// Bundle of UART byte, operand buffer, product buffer and multiplier
// control signals seen by the command sequencer.
interface uart_mm_ctrl_if #(
  parameter int AW = 6
);
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          tx_done;
  logic          send_data;
  logic [7:0]    tx_data;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [7:0]    a_height;
  logic [7:0]    a_width;
  logic [7:0]    h_width;
  logic          mm_start;
  logic          mm_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          busy;
  logic          err;

  modport master (
    input  rx_done, rx_data, tx_done, mm_done, rd_data,
    output send_data, tx_data, wr_en, wr_sel, wr_addr,
    output wr_data, a_height, a_width, h_width,
    output mm_start, rd_en, rd_addr, busy, err
  );

  modport slave (
    output rx_done, rx_data, tx_done, mm_done, rd_data,
    input  send_data, tx_data, wr_en, wr_sel, wr_addr,
    input  wr_data, a_height, a_width, h_width,
    input  mm_start, rd_en, rd_addr, busy, err
  );
endinterface

// File: rtl/byte_word_packer.sv
// Shifts received bytes MSB first into a 32-bit word and pulses
// o_valid the cycle after the fourth byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_valid
);
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_valid) begin
        r_word  <= {r_word[23:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
        r_valid <= (r_cnt == 2'd3);
      end
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;
endmodule

// File: rtl/uart_mm_ctrl.sv
// Parses host matrix-multiply packets, loads operand buffers, runs the
// multiplier and streams the product back one byte at a time.
module uart_mm_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int MAX_DIM     = 8,
  parameter int AW          = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic            clk,
  input logic            rst,
  uart_mm_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        r_state;
  logic [7:0]    r_ah, r_aw, r_hh, r_hw;
  logic [1:0]    r_dim_cnt;
  logic [1:0]    r_byte_cnt;
  logic [15:0]   r_word_cnt;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_addr;
  logic [TW-1:0] r_idle;
  logic [31:0]   r_shift;
  logic [7:0]    r_tx_data;
  logic          r_send;
  logic          r_wr_sel;
  logic          r_mm_start;
  logic          r_rd_en;
  logic          r_err;

  logic          w_load;
  logic          w_track;
  logic          w_timed;
  logic          w_ok;
  logic          w_word_valid;
  logic [31:0]   w_word;
  logic [15:0]   w_na, w_nh, w_nc;
  logic [15:0]   w_wcnt_nx;

  assign w_load  = (r_state == LOAD_A) || (r_state == LOAD_H);
  assign w_track = w_load || (r_state == DIM);
  // an arriving byte takes priority over the idle terminal count
  assign w_timed = w_track && !bus.rx_done && (r_idle == T_LAST);

  assign w_ok = dim_ok(r_ah, MAX_DIM) && dim_ok(r_aw, MAX_DIM) &&
                dim_ok(r_hh, MAX_DIM) && dim_ok(r_hw, MAX_DIM) &&
                (r_aw == r_hh);

  assign w_na      = {8'd0, r_ah} * {8'd0, r_aw};
  assign w_nh      = {8'd0, r_aw} * {8'd0, r_hw};
  assign w_nc      = {8'd0, r_ah} * {8'd0, r_hw};
  assign w_wcnt_nx = r_word_cnt + 16'd1;

  byte_word_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_load),
    .i_valid (w_load && bus.rx_done),
    .i_byte  (bus.rx_data),
    .o_word  (w_word),
    .o_valid (w_word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ah       <= '0;
      r_aw       <= '0;
      r_hh       <= '0;
      r_hw       <= '0;
      r_dim_cnt  <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_idle     <= '0;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_send     <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_mm_start <= 1'b0;
      r_rd_en    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_send     <= 1'b0;
      r_mm_start <= 1'b0;
      r_rd_en    <= 1'b0;
      if (w_timed) begin
        r_err   <= 1'b1;
        r_idle  <= '0;
        r_state <= IDLE;
      end else begin
        r_idle <= (w_track && !bus.rx_done) ? r_idle + TW'(1) : '0;
        unique case (r_state)
          IDLE: begin
            if (bus.rx_done && bus.rx_data == CMD_MATRIX_MULT) begin
              r_err     <= 1'b0;
              r_dim_cnt <= '0;
              r_state   <= DIM;
            end
          end
          DIM: begin
            if (bus.rx_done) begin
              unique case (r_dim_cnt)
                2'd0: r_ah <= bus.rx_data;
                2'd1: r_aw <= bus.rx_data;
                2'd2: r_hh <= bus.rx_data;
                2'd3: r_hw <= bus.rx_data;
              endcase
              r_dim_cnt <= r_dim_cnt + 2'd1;
              if (r_dim_cnt == 2'd3) r_state <= CHECK;
            end
          end
          CHECK: begin
            r_send <= 1'b1;
            if (w_ok) begin
              r_tx_data <= ACK;
              r_state   <= SEND_ACK;
            end else begin
              r_tx_data <= NACK;
              r_err     <= 1'b1;
              r_state   <= SEND_NACK;
            end
          end
          SEND_ACK: begin
            if (bus.tx_done) begin
              r_wr_addr  <= '0;
              r_word_cnt <= '0;
              r_wr_sel   <= 1'b0;
              r_state    <= LOAD_A;
            end
          end
          SEND_NACK: begin
            if (bus.tx_done) r_state <= IDLE;
          end
          LOAD_A: begin
            if (w_word_valid) begin
              if (w_wcnt_nx == w_na) begin
                r_wr_addr  <= '0;
                r_word_cnt <= '0;
                r_wr_sel   <= 1'b1;
                r_state    <= LOAD_H;
              end else begin
                r_wr_addr  <= r_wr_addr + AW'(1);
                r_word_cnt <= w_wcnt_nx;
              end
            end
          end
          LOAD_H: begin
            if (w_word_valid) begin
              r_wr_addr <= r_wr_addr + AW'(1);
              if (w_wcnt_nx == w_nh) begin
                r_word_cnt <= '0;
                r_mm_start <= 1'b1;
                r_state    <= START;
              end else begin
                r_word_cnt <= w_wcnt_nx;
              end
            end
          end
          START: begin
            r_rd_addr <= '0;
            r_state   <= COMPUTE;
          end
          COMPUTE: begin
            if (bus.mm_done) begin
              r_rd_en <= 1'b1;
              r_state <= RD;
            end
          end
          RD: r_state <= RD_CAP;
          RD_CAP: begin
            r_shift    <= bus.rd_data;
            r_byte_cnt <= '0;
            r_state    <= TX_BYTE;
          end
          TX_BYTE: begin
            r_tx_data <= r_shift[31:24];
            r_shift   <= {r_shift[23:0], 8'h00};
            r_send    <= 1'b1;
            r_state   <= TX_WAIT;
          end
          TX_WAIT: begin
            if (bus.tx_done) begin
              if (r_byte_cnt == 2'd3) begin
                if (w_wcnt_nx == w_nc) begin
                  r_word_cnt <= '0;
                  r_state    <= IDLE;
                end else begin
                  r_word_cnt <= w_wcnt_nx;
                  r_rd_addr  <= r_rd_addr + AW'(1);
                  r_rd_en    <= 1'b1;
                  r_state    <= RD;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_state    <= TX_BYTE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.send_data = r_send;
  assign bus.tx_data   = r_tx_data;
  assign bus.wr_en     = w_word_valid;
  assign bus.wr_sel    = r_wr_sel;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = w_word;
  assign bus.a_height  = r_ah;
  assign bus.a_width   = r_aw;
  assign bus.h_width   = r_hw;
  assign bus.mm_start  = r_mm_start;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;
endmodule

// File: tb/tb_uart_mm_ctrl.sv
// Scoreboard bench for uart_mm_ctrl: host packets in, expected writes and
// transmitted bytes queued up front and matched by independent monitors.
module tb_uart_mm_ctrl;
  import mm_ctrl_pkg::*;

  localparam int AW  = 6;
  localparam int TMO = 200;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_mm_ctrl_if #(.AW(AW)) bus ();

  uart_mm_ctrl #(
    .MAX_DIM     (8),
    .AW          (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tx_cnt = 0;
  int starts = 0;

  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  logic [31:0] op_a[64];
  logic [31:0] op_h[64];
  logic [31:0] prod_mem[64];

  logic [7:0]    tx_got;
  logic [7:0]    tx_e;
  wr_t           wr_e;
  logic [AW-1:0] rd_a;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired, got none want event", nm);
  endtask

  function automatic logic [127:0] all_out();
    return {bus.send_data, bus.tx_data, bus.wr_en, bus.wr_sel,
            bus.wr_addr, bus.wr_data, bus.a_height, bus.a_width,
            bus.h_width, bus.mm_start, bus.rd_en, bus.rd_addr,
            bus.busy, bus.err};
  endfunction

  // UART transmitter model and tx scoreboard
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_data) begin
        tx_got = bus.tx_data;
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra: got %0h want none", tx_got);
        end else begin
          tx_e = exp_tx.pop_front();
          chk("tx_byte", tx_got, tx_e);
        end
        repeat (3) @(negedge clk);
        if (!rst) chk("tx_hold", bus.tx_data, tx_got);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        tx_cnt++;
      end
    end
  end

  // operand write scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_extra: got sel=%0d addr=%0d data=%h want none",
                   bus.wr_sel, bus.wr_addr, bus.wr_data);
        end else begin
          wr_e = exp_wr.pop_front();
          chk("wr", {bus.wr_sel, bus.wr_addr, bus.wr_data}, wr_e);
        end
      end
    end
  end

  // multiplier model
  initial begin
    bus.mm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mm_start) begin
        starts++;
        repeat (20) @(negedge clk);
        bus.mm_done = 1'b1;
        @(negedge clk);
        bus.mm_done = 1'b0;
      end
    end
  end

  // product buffer: data only valid from the cycle after rd_en
  initial begin
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.rd_en) begin
        rd_a = bus.rd_addr;
        bus.rd_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.rd_data = prod_mem[rd_a];
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic s, input logic [AW-1:0] a,
                           input logic [31:0] d);
    exp_wr.push_back(wr_t'({s, a, d}));
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_tx_word(input logic [31:0] d);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input string nm);
    for (int i = 0; i < 400; i++) begin
      if (tx_cnt >= n) return;
      @(negedge clk);
    end
    flag(nm);
  endtask

  task automatic wait_start(input int n, input string nm);
    for (int i = 0; i < 100; i++) begin
      if (starts >= n) return;
      @(negedge clk);
    end
    flag(nm);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin
      if (!bus.busy) return;
      @(negedge clk);
    end
    flag(nm);
  endtask

  task automatic header(input logic [7:0] ah, input logic [7:0] aw,
                        input logic [7:0] hh, input logic [7:0] hw,
                        input logic ok);
    exp_tx.push_back(ok ? ACK : NACK);
    send_byte(CMD_MATRIX_MULT);
    send_byte(ah);
    send_byte(aw);
    send_byte(hh);
    send_byte(hw);
  endtask

  task automatic run_packet(input int ah, input int aw, input int hw);
    int n0, s0;
    n0 = tx_cnt;
    s0 = starts;
    header(8'(ah), 8'(aw), 8'(aw), 8'(hw), 1'b1);
    for (int k = 0; k < ah * hw; k++) push_tx_word(prod_mem[k]);
    wait_tx(n0 + 1, "ack_wait");
    chk("err_after_ack", bus.err, 1'b0);
    for (int i = 0; i < ah * aw; i++) send_word(1'b0, AW'(i), op_a[i]);
    for (int i = 0; i < aw * hw; i++) send_word(1'b1, AW'(i), op_h[i]);
    wait_start(s0 + 1, "start_wait");
  endtask

  task automatic load_2x2();
    op_a[0] = 32'h3F800000; op_a[1] = 32'h40000000;
    op_a[2] = 32'h40400000; op_a[3] = 32'h40800000;
    op_h[0] = 32'h3F800000; op_h[1] = 32'h40000000;
    op_h[2] = 32'h40400000; op_h[3] = 32'h40800000;
    prod_mem[0] = 32'h40E00000; prod_mem[1] = 32'h41200000;
    prod_mem[2] = 32'h41700000; prod_mem[3] = 32'h41B00000;
  endtask

  initial begin
    int n0;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), '0);
    rst = 1'b0;

    send_byte(8'h00);
    send_byte(8'hFF);
    chk("garbage_busy", bus.busy, 1'b0);

    load_2x2();
    run_packet(2, 2, 2);
    send_byte(CMD_MATRIX_MULT);
    send_byte(8'h11);
    chk("compute_busy", bus.busy, 1'b1);
    wait_idle(800, "t2x2_idle");
    chk("t2x2_err", bus.err, 1'b0);
    chk("t2x2_starts", starts, 1);

    n0 = tx_cnt;
    header(8'd2, 8'd3, 8'd2, 8'd2, 1'b0);
    wait_tx(n0 + 1, "nack1_wait");
    wait_idle(50, "nack1_idle");
    chk("nack1_err", bus.err, 1'b1);
    chk("nack1_dims", {bus.a_height, bus.a_width, bus.h_width},
        24'h020302);

    n0 = tx_cnt;
    header(8'd0, 8'd2, 8'd2, 8'd2, 1'b0);
    wait_tx(n0 + 1, "nack0_wait");
    wait_idle(50, "nack0_idle");
    chk("nack0_err", bus.err, 1'b1);

    n0 = tx_cnt;
    header(8'd2, 8'd2, 8'd2, 8'd9, 1'b0);
    wait_tx(n0 + 1, "nack9_wait");
    wait_idle(50, "nack9_idle");
    chk("nack9_err", bus.err, 1'b1);

    for (int i = 0; i < 64; i++) begin
      op_a[i]     = 32'h30000000 | i;
      op_h[i]     = 32'h50000000 | i;
      prod_mem[i] = 32'hC0000000 | (i * 3);
    end
    run_packet(8, 8, 8);
    wait_idle(4000, "t8x8_idle");
    chk("t8x8_dims", {bus.a_height, bus.a_width, bus.h_width},
        24'h080808);
    chk("t8x8_starts", starts, 2);

    n0 = tx_cnt;
    header(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    wait_tx(n0 + 1, "tmo_ack");
    send_word(1'b0, '0, 32'h3F800000);
    send_byte(8'h40);
    send_byte(8'h00);
    repeat (TMO - 20) @(negedge clk);
    chk("tmo_not_yet", bus.busy, 1'b1);
    wait_idle(60, "tmo_idle");
    chk("tmo_err", bus.err, 1'b1);

    op_a[0] = 32'h3F800000;
    op_h[0] = 32'h40000000;
    prod_mem[0] = 32'h40000000;
    run_packet(1, 1, 1);
    wait_idle(200, "t1x1_idle");
    chk("t1x1_err", bus.err, 1'b0);
    chk("t1x1_starts", starts, 3);

    load_2x2();
    n0 = tx_cnt;
    run_packet(2, 2, 2);
    wait_tx(n0 + 4, "rst_tx_wait");
    #2 rst = 1'b1;
    #1 chk("rst_async", all_out(), '0);
    @(negedge clk);
    chk("rst_hold", all_out(), '0);
    exp_tx.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_tx_quiet", exp_tx.size(), 0);

    run_packet(2, 2, 2);
    wait_idle(800, "post_rst_idle");
    chk("post_rst_err", bus.err, 1'b0);

    repeat (10) @(negedge clk);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("total_starts", starts, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_mm_ctrl.md
Name: uart_mm_ctrl

Overview:
- Command sequencer between the UART byte interface and the matrix-multiply datapath of the square MTP test design.
- Parses host packets: opcode, four dimension bytes, then A and H operands as big-endian IEEE-754 singles. Validates the dimensions and returns ACK or NACK.
- Writes operands into the operand buffers, starts the multiplier, then streams the product matrix back over UART, MSB byte first.

Parameters:
MAX_DIM, 8, largest legal matrix dimension (1..MAX_DIM)
AW, 6, buffer address width; must satisfy 2**AW >= MAX_DIM*MAX_DIM
TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes of one packet before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_done  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received byte
tx_done  in  1  one-cycle pulse, UART finished the current byte
send_data  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  8  byte to transmit, held stable from send_data until tx_done
wr_en  out  1  operand buffer write strobe
wr_sel  out  1  0 = A buffer, 1 = H buffer
wr_addr  out  AW  row-major operand index
wr_data  out  32  assembled float
a_height, a_width, h_width  out  8 each  latched dimensions for the datapath
mm_start  out  1  one-cycle start pulse to the multiplier
mm_done  in  1  one-cycle pulse, product buffer complete
rd_en  out  1  product buffer read strobe
rd_addr  out  AW  row-major product index
rd_data  in  32  product word, valid 1 cycle after rd_en
busy  out  1  high in every state except IDLE
err  out  1  sticky; set on NACK or timeout, cleared by the next valid opcode

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- IDLE: rx_done with rx_data==CMD_MATRIX_MULT -> DIM, and err clears. Any other byte is dropped.
- DIM: the next four rx bytes latch in order: a_height, a_width, h_height, h_width. Then -> CHECK.
- CHECK (1 cycle): the packet is valid iff all dims are in 1..MAX_DIM and a_width==h_height.
  - Valid -> SEND_ACK (tx_data=ACK).
  - Invalid -> SEND_NACK (tx_data=NACK), err=1.
- SEND_x: pulse send_data, then wait for tx_done.
  - After ACK -> LOAD_A.
  - After NACK -> IDLE.
- LOAD_A / LOAD_H: a byte counter 0..3 shifts bytes in MSB first.
  - On the 4th byte, wr_en pulses the next cycle with the current wr_addr and wr_sel, then wr_addr increments.
  - After a_height*a_width words, wr_addr resets to 0 and state -> LOAD_H.
  - After a_width*h_width words -> START.
- START: mm_start for 1 cycle -> COMPUTE. COMPUTE waits for mm_done.
- RD: rd_en for 1 cycle. The word is captured into a shift register on the following cycle. Then 4 x (send_data, wait tx_done), MSB first.
  - This repeats for a_height*h_width words, with rd_addr incrementing after each word.
  - After the final tx_done -> IDLE.
- Size products are computed at 2*8 bits and compared against the word counter. Counters never wrap, because dimensions are bounded by CHECK.
- rx bytes are dropped in CHECK, SEND_x, START, COMPUTE and RD/TX.
- Timeout:
  - In DIM/LOAD_A/LOAD_H, the idle counter resets on each rx_done.
  - On reaching TIMEOUT_CYC: err=1, -> IDLE, with no write for the partial word.
  - Not applied in other states.
- A tx_done arriving in a state not waiting for it is ignored.
- A simultaneous rx_done and timeout terminal count: rx_done wins.
- Reset mid-operation: immediate return to IDLE. Buffer contents are left undefined.

Decomposition:
- Package mm_ctrl_pkg holds:
  - CMD_MATRIX_MULT=8'h4D, ACK=8'h06, NACK=8'h15.
  - state_t enum: IDLE, DIM, CHECK, SEND_ACK, SEND_NACK, LOAD_A, LOAD_H, START, COMPUTE, RD, RD_CAP, TX_BYTE, TX_WAIT.
- One sub-module, byte_word_packer: a 4-byte MSB-first shift-in with a byte counter and word_valid pulse, reused by LOAD_A and LOAD_H.
- The TX unpack stays inline.

Test Plan:
- 2x2 times 2x2, both operands 1.0,2.0,3.0,4.0 -> ACK; 8 wr_en writes (sel 0 addr 0..3, sel 1 addr 0..3), first wr_data=32'h3F800000; mm_start once. Model product 7,10,15,22 -> 16 tx bytes, starting 40 E0 00 00.
- Dims 2,3,2,2 (a_width!=h_height) -> NACK byte, err=1, no wr_en, back to IDLE; the next valid opcode clears err.
- Dim 0 or MAX_DIM+1 -> NACK. Dims 8,8,8,8 -> ACK and 64 writes per buffer, last wr_addr=63.
- Stop after 6 operand bytes, idle TIMEOUT_CYC cycles -> err=1, IDLE, only 1 wr_en seen; a following full packet succeeds.
- Garbage bytes 0x00, 0xFF before the opcode are ignored. Extra bytes sent during COMPUTE produce no writes and no state change.
- Assert rst during TX of the product -> all outputs 0 next cycle, busy=0; a subsequent packet completes normally.
